// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked opcode -> ALU-control decoder with multi-cycle shift-class hold.
// Optional sticky illegal-opcode trap enabled by defining ALU_CTRL_TRAP_EN.
module alu_ctrl_seq #(
    parameter int unsigned OPCODE_W     = 4,
    parameter int unsigned CTRL_W       = 4,
    parameter int unsigned MULTI_CYCLES = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CTRL_W-1:0]   out_alu_ctrl,
    output logic                out_illegal,
    output logic                out_multi,
    output logic                busy,
    output logic                alu_step,
    output logic                trap
);

    localparam int unsigned CNT_W = (MULTI_CYCLES > 1) ? $clog2(MULTI_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ITER,
        ST_FULL
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                illegal_q, illegal_d;
    logic                multi_q, multi_d;
    logic                trap_q, trap_d;

    logic [3:0]          op_lo;
    logic                op_hi_set;
    logic [CTRL_W-1:0]   dec_ctrl;
    logic                dec_illegal;
    logic                dec_multi;

    // Opcode decode; any upper bit set forces illegal
    always_comb begin
        op_lo       = in_opcode[3:0];
        op_hi_set   = (in_opcode >> 4) != '0;
        dec_ctrl    = '1;
        dec_illegal = 1'b0;
        dec_multi   = 1'b0;
        case (op_lo)
            4'd1:    dec_ctrl = CTRL_W'(3'd0);
            4'd3:    dec_ctrl = CTRL_W'(3'd1);
            4'd4:    dec_ctrl = CTRL_W'(3'd2);
            4'd5:    dec_ctrl = CTRL_W'(3'd3);
            4'd6:    dec_ctrl = CTRL_W'(3'd4);
            4'd7:    dec_ctrl = CTRL_W'(3'd5);
            4'd8:    dec_ctrl = CTRL_W'(3'd6);
            4'd9:    dec_ctrl = CTRL_W'(3'd7);
            default: dec_illegal = 1'b1;
        endcase
        if (op_hi_set) begin
            dec_ctrl    = '1;
            dec_illegal = 1'b1;
        end
        dec_multi = !dec_illegal && (op_lo == 4'd8 || op_lo == 4'd9);
    end

    // Next-state and handshake logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        multi_d   = multi_q;
        trap_d    = trap_q;
        in_ready  = 1'b0;

        case (state_q)
            ST_EMPTY: in_ready = !trap_q;
            ST_ITER: begin
                if (cnt_q == '0) begin
                    state_d = ST_FULL;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FULL: begin
                in_ready = out_ready && !trap_q;
                if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (in_ready && in_valid) begin
`ifdef ALU_CTRL_TRAP_EN
            if (dec_illegal) begin
                trap_d  = 1'b1;
                state_d = ST_EMPTY;
            end else begin
`else
            begin
`endif
                ctrl_d    = dec_ctrl;
                illegal_d = dec_illegal;
                multi_d   = dec_multi;
                if (dec_multi && MULTI_CYCLES > 1) begin
                    state_d = ST_ITER;
                    cnt_d   = CNT_W'(MULTI_CYCLES - 1);
                end else begin
                    state_d = ST_FULL;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            multi_q   <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            multi_q   <= multi_d;
            trap_q    <= trap_d;
        end
    end

    assign out_valid    = (state_q == ST_FULL);
    assign busy         = (state_q == ST_ITER);
    assign alu_step     = (state_q == ST_ITER);
    assign out_alu_ctrl = ctrl_q;
    assign out_illegal  = illegal_q;
    assign out_multi    = multi_q;
    assign trap         = trap_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized + directed bench for alu_ctrl_seq against a transaction-level reference model.
module tb_alu_ctrl_seq;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned CTRL_W   = 4;
    localparam int unsigned MC       = 3;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [OPCODE_W-1:0] in_opcode = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [CTRL_W-1:0]   out_alu_ctrl;
    logic                out_illegal;
    logic                out_multi;
    logic                busy;
    logic                alu_step;
    logic                trap;

    int errors = 0;
    int checks = 0;

    alu_ctrl_seq #(.OPCODE_W(OPCODE_W), .CTRL_W(CTRL_W), .MULTI_CYCLES(MC)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_ctrl(out_alu_ctrl),
        .out_illegal(out_illegal), .out_multi(out_multi),
        .busy(busy), .alu_step(alu_step), .trap(trap)
    );

    always #5 clock = ~clock;

    // Reference model: one op in flight with a count of remaining shift steps
    int           m_have  = 0;
    int           m_steps = 0;
    int           m_ctrl  = 0;
    int           m_ill   = 0;
    int           m_multi = 0;
    int           m_trap  = 0;
    int           dec_tbl [16];

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] op, input logic ordy);
        int exp_rdy;
        int exp_vld;
        int exp_busy;
        int code;
        @(negedge clock);
        reset = r; in_valid = v; in_opcode = op; out_ready = ordy;
        #1;
        exp_vld  = (m_have != 0 && m_steps == 0) ? 1 : 0;
        exp_busy = (m_have != 0 && m_steps > 0) ? 1 : 0;
        exp_rdy  = (m_trap == 0 && (m_have == 0 || (exp_vld != 0 && ordy))) ? 1 : 0;
        check_eq("in_ready",  int'(in_ready),     exp_rdy);
        check_eq("out_valid", int'(out_valid),    exp_vld);
        check_eq("busy",      int'(busy),         exp_busy);
        check_eq("alu_step",  int'(alu_step),     exp_busy);
        check_eq("ctrl",      int'(out_alu_ctrl), m_ctrl);
        check_eq("illegal",   int'(out_illegal),  m_ill);
        check_eq("multi",     int'(out_multi),    m_multi);
        check_eq("trap",      int'(trap),         m_trap);
        if (r) begin
            m_have = 0; m_steps = 0; m_ctrl = 0; m_ill = 0; m_multi = 0; m_trap = 0;
        end else begin
            if (m_have != 0 && m_steps > 0) m_steps--;
            else if (m_have != 0 && ordy) m_have = 0;
            if (exp_rdy != 0 && v) begin
                code = dec_tbl[op];
`ifdef ALU_CTRL_TRAP_EN
                if (code < 0) begin
                    m_trap = 1;
                    m_have = 0;
                end else begin
`else
                begin
`endif
                    m_have  = 1;
                    m_ill   = (code < 0) ? 1 : 0;
                    m_ctrl  = (code < 0) ? (1 << CTRL_W) - 1 : code;
                    m_multi = (code == 6 || code == 7) ? 1 : 0;
                    m_steps = (m_multi != 0 && MC > 1) ? MC : 0;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) dec_tbl[i] = -1;
        dec_tbl[1] = 0; dec_tbl[3] = 1; dec_tbl[4] = 2; dec_tbl[5] = 3;
        dec_tbl[6] = 4; dec_tbl[7] = 5; dec_tbl[8] = 6; dec_tbl[9] = 7;

        repeat (2) @(posedge clock);
        step(1, 0, 4'd0, 0);

        // Single-cycle op, then back-to-back stream
        step(0, 1, 4'd4, 1);
        step(0, 1, 4'd1, 1);
        step(0, 1, 4'd3, 1);
        step(0, 1, 4'd5, 1);
        step(0, 0, 4'd0, 1);
        step(0, 0, 4'd0, 1);

        // Shift class: step pulses then result
        step(0, 1, 4'd8, 1);
        repeat (5) step(0, 0, 4'd0, 1);

        // Backpressure hold, then release with same-cycle accept
        step(0, 1, 4'd7, 0);
        repeat (4) step(0, 1, 4'd1, 0);
        step(0, 1, 4'd4, 1);
        step(0, 0, 4'd0, 1);

        // Illegal opcode
        step(0, 1, 4'hF, 1);
        repeat (3) step(0, 1, 4'd3, 1);
        step(1, 0, 4'd0, 1);

        // Reset during second ITER cycle, then recover
        step(0, 1, 4'd9, 1);
        step(0, 0, 4'd0, 1);
        step(1, 0, 4'd0, 1);
        step(0, 1, 4'd6, 1);
        step(0, 0, 4'd0, 1);
        step(0, 0, 4'd0, 1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic       r;
            logic       v;
            logic       rd;
            logic [3:0] op;
            r  = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) != 0);
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 9));
            step(r, v, op, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
